// File: rtl/fp_add_pipe_if.sv
// fp_add_pipe_if: operand/result handshake bundle for the FP adder
// slave = adder side, master = producer/consumer side
interface fp_add_pipe_if #(
  parameter int EW = 6,
  parameter int MW = 22,
  parameter int TW = 4
) ();
  logic          in_valid;
  logic          in_ready;
  logic          in_sub;
  logic          in_a_sgn;
  logic          in_b_sgn;
  logic [EW-1:0] in_a_exp;
  logic [EW-1:0] in_b_exp;
  logic [MW-1:0] in_a_man;
  logic [MW-1:0] in_b_man;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic          out_sgn;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_man;
  logic [TW-1:0] out_tag;
  logic          out_ovf;
  logic          ovf_sticky;
  logic          clr_sticky;

  modport slave (
    input  in_valid, in_sub,
    input  in_a_sgn, in_b_sgn,
    input  in_a_exp, in_b_exp,
    input  in_a_man, in_b_man,
    input  in_tag, out_ready,
    input  clr_sticky,
    output in_ready, out_valid,
    output out_sgn, out_exp,
    output out_man, out_tag,
    output out_ovf, ovf_sticky
  );

  modport master (
    output in_valid, in_sub,
    output in_a_sgn, in_b_sgn,
    output in_a_exp, in_b_exp,
    output in_a_man, in_b_man,
    output in_tag, out_ready,
    output clr_sticky,
    input  in_ready, out_valid,
    input  out_sgn, out_exp,
    input  out_man, out_tag,
    input  out_ovf, ovf_sticky
  );
endinterface

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: pipelined FP add/sub with valid/ready and tag
// capture, compare/swap, align, add, normalise; all stages move on adv
module fp_add_pipe #(
  parameter int EW = 6,
  parameter int MW = 22,
  parameter int TW = 4
) (
  input logic          clk,
  input logic          rst_n,
  fp_add_pipe_if.slave io
);

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic          as;
    logic [EW-1:0] ae;
    logic [MW-1:0] am;
    logic          bs;
    logic [EW-1:0] be;
    logic [MW-1:0] bm;
  } cap_t;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic          byp;
    logic          sl;
    logic          ss;
    logic [EW-1:0] el;
    logic [MW-1:0] ml;
    logic [MW-1:0] ms;
    logic [EW:0]   d;
  } cmp_t;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic          byp;
    logic          sl;
    logic          ss;
    logic [EW-1:0] el;
    logic [MW-1:0] ml;
    logic [MW-1:0] ms;
  } aln_t;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic          byp;
    logic          sg;
    logic [EW-1:0] el;
    logic [MW:0]   m;
  } add_t;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic          sg;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    logic          ovf;
  } out_t;

  cap_t cap_q, cap_d;
  cmp_t s1_q, s1_d;
  aln_t s2_q, s2_d;
  add_t s3_q, s3_d;
  out_t out_q, out_d;
  logic sticky_q, sticky_d;
  logic adv;

  assign adv         = !out_q.v | io.out_ready;
  assign io.in_ready = adv;

  assign io.out_valid  = out_q.v;
  assign io.out_sgn    = out_q.sg;
  assign io.out_exp    = out_q.e;
  assign io.out_man    = out_q.m;
  assign io.out_tag    = out_q.tag;
  assign io.out_ovf    = out_q.ovf;
  assign io.ovf_sticky = sticky_q;

  always_comb begin
    cap_d     = '0;
    cap_d.v   = io.in_valid;
    cap_d.tag = io.in_tag;
    cap_d.as  = io.in_a_sgn;
    cap_d.ae  = io.in_a_exp;
    cap_d.am  = io.in_a_man;
    cap_d.bs  = io.in_b_sgn ^ io.in_sub;
    cap_d.be  = io.in_b_exp;
    cap_d.bm  = io.in_b_man;
  end

  logic az, bz;
  assign az = (cap_q.am == '0);
  assign bz = (cap_q.bm == '0);

  always_comb begin
    s1_d     = '0;
    s1_d.v   = cap_q.v;
    s1_d.tag = cap_q.tag;
    if (az ^ bz) begin
      s1_d.byp = 1'b1;
      s1_d.sl  = az ? cap_q.bs : cap_q.as;
      s1_d.el  = az ? cap_q.be : cap_q.ae;
      s1_d.ml  = az ? cap_q.bm : cap_q.am;
    end else if (cap_q.be > cap_q.ae) begin
      s1_d.sl = cap_q.bs;
      s1_d.el = cap_q.be;
      s1_d.ml = cap_q.bm;
      s1_d.ss = cap_q.as;
      s1_d.ms = cap_q.am;
      s1_d.d  = {1'b0, cap_q.be} - {1'b0, cap_q.ae};
    end else begin
      s1_d.sl = cap_q.as;
      s1_d.el = cap_q.ae;
      s1_d.ml = cap_q.am;
      s1_d.ss = cap_q.bs;
      s1_d.ms = cap_q.bm;
      s1_d.d  = {1'b0, cap_q.ae} - {1'b0, cap_q.be};
    end
  end

  always_comb begin
    s2_d     = '0;
    s2_d.v   = s1_q.v;
    s2_d.tag = s1_q.tag;
    s2_d.byp = s1_q.byp;
    s2_d.sl  = s1_q.sl;
    s2_d.ss  = s1_q.ss;
    s2_d.el  = s1_q.el;
    s2_d.ml  = s1_q.ml;
    if (32'(s1_q.d) >= MW) s2_d.ms = '0;
    else                   s2_d.ms = s1_q.ms >> s1_q.d;
  end

  logic [MW+1:0] dif;
  assign dif = {2'b0, s2_q.ml} - {2'b0, s2_q.ms};

  always_comb begin
    s3_d     = '0;
    s3_d.v   = s2_q.v;
    s3_d.tag = s2_q.tag;
    s3_d.byp = s2_q.byp;
    s3_d.el  = s2_q.el;
    s3_d.sg  = s2_q.sl;
    if (s2_q.byp) begin
      s3_d.m = {1'b0, s2_q.ml};
    end else if (s2_q.sl == s2_q.ss) begin
      s3_d.m = {1'b0, s2_q.ml} + {1'b0, s2_q.ms};
    end else if (dif[MW+1]) begin
      s3_d.m  = {1'b0, s2_q.ms} - {1'b0, s2_q.ml};
      s3_d.sg = s2_q.ss;
    end else begin
      s3_d.m = dif[MW:0];
    end
  end

  int            lz;
  logic [EW-1:0] sh;

  // left shift is capped by the exponent so small results stay denormal
  always_comb begin
    lz = MW;
    for (int i = 0; i < MW; i++) begin
      if (s3_q.m[i]) lz = MW - 1 - i;
    end
    if ($unsigned(lz) < 32'(s3_q.el)) sh = EW'(lz);
    else                              sh = s3_q.el;
  end

  always_comb begin
    out_d     = '0;
    out_d.v   = s3_q.v;
    out_d.tag = s3_q.tag;
    if (s3_q.byp) begin
      out_d.sg = s3_q.sg;
      out_d.e  = s3_q.el;
      out_d.m  = s3_q.m[MW-1:0];
    end else if (s3_q.m == '0) begin
      out_d.sg = 1'b0;
    end else if (s3_q.m[MW]) begin
      out_d.sg = s3_q.sg;
      if (&s3_q.el) begin
        out_d.e   = '1;
        out_d.m   = '1;
        out_d.ovf = 1'b1;
      end else begin
        out_d.e = s3_q.el + 1'b1;
        out_d.m = s3_q.m[MW:1];
      end
    end else begin
      out_d.sg = s3_q.sg;
      out_d.e  = s3_q.el - sh;
      out_d.m  = s3_q.m[MW-1:0] << sh;
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (io.clr_sticky) sticky_d = 1'b0;
    if (out_q.v && io.out_ready && out_q.ovf)
      sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      out_q <= '0;
    end else if (adv) begin
      cap_q <= cap_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      out_q <= out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed vectors, arithmetic reference model,
// scoreboard compare on every output transfer
module tb_fp_add_pipe;
  localparam int EW = 6;
  localparam int MW = 22;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_add_pipe_if #(.EW(EW), .MW(MW), .TW(TW)) io ();

  fp_add_pipe #(.EW(EW), .MW(MW), .TW(TW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nout = 0;
  logic [TW-1:0] tg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          s;
    int          e;
    longint      m;
    bit          ovf;
    logic [TW-1:0] tag;
  } res_t;

  res_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(logic s, logic [EW-1:0] e,
      logic [MW-1:0] m, logic [TW-1:0] t, logic o);
    return {30'b0, s, e, m, t, o};
  endfunction

  // value arithmetic on signed integers; truncation of the smaller
  // operand is floor division by 2^d
  function automatic res_t model(bit sub, bit as, int ae, longint am,
      bit bs, int be, longint bm, logic [TW-1:0] tag);
    res_t r;
    bit bse, sl, ss;
    int el, es, d;
    longint ml, ms, sm, sum, mag;
    bse = bs ^ sub;
    r.tag = tag; r.ovf = 0; r.s = 0; r.e = 0; r.m = 0;
    if ((am == 0) != (bm == 0)) begin
      if (am == 0) begin r.s = bse; r.e = be; r.m = bm; end
      else begin r.s = as; r.e = ae; r.m = am; end
      return r;
    end
    if (be > ae) begin
      sl = bse; el = be; ml = bm; ss = as; es = ae; ms = am;
    end else begin
      sl = as; el = ae; ml = am; ss = bse; es = be; ms = bm;
    end
    d = el - es;
    sm = (d >= MW) ? 0 : ms / (longint'(1) << d);
    sum = (sl ? -ml : ml) + (ss ? -sm : sm);
    if (sum == 0) return r;
    r.s = (sum < 0);
    mag = (sum < 0) ? -sum : sum;
    r.e = el;
    if (mag >= (longint'(1) << MW)) begin
      mag = mag / 2;
      r.e++;
      if (r.e > (1 << EW) - 1) begin
        r.e = (1 << EW) - 1;
        mag = (longint'(1) << MW) - 1;
        r.ovf = 1;
      end
    end else begin
      while (mag < (longint'(1) << (MW - 1)) && r.e > 0) begin
        mag = mag * 2;
        r.e--;
      end
    end
    r.m = mag;
    return r;
  endfunction

  logic [63:0] held;
  logic [63:0] cur;
  bit stall_prev = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
      sbq.delete();
    end else begin
      cur = pk(io.out_sgn, io.out_exp, io.out_man,
               io.out_tag, io.out_ovf);
      if (stall_prev && io.out_valid)
        chk("stall_hold", cur, held);
      if (io.out_valid && io.out_ready) begin
        nout++;
        if (sbq.size() == 0) begin
          chk("sb_nonempty", 64'(sbq.size()), 64'd1);
        end else begin
          res_t r;
          r = sbq.pop_front();
          chk("model", cur, pk(r.s, r.e[EW-1:0], r.m[MW-1:0],
                                r.tag, r.ovf));
        end
      end
      stall_prev = io.out_valid && !io.out_ready;
      held = cur;
      if (io.in_valid && io.in_ready)
        sbq.push_back(model(io.in_sub, io.in_a_sgn,
          int'(io.in_a_exp), longint'(io.in_a_man), io.in_b_sgn,
          int'(io.in_b_exp), longint'(io.in_b_man), io.in_tag));
    end
  end

  task automatic drive(bit sub, bit as, int ae, longint am,
                       bit bs, int be, longint bm, logic [TW-1:0] t);
    io.in_valid = 1'b1;
    io.in_sub   = sub;
    io.in_a_sgn = as;
    io.in_a_exp = ae[EW-1:0];
    io.in_a_man = am[MW-1:0];
    io.in_b_sgn = bs;
    io.in_b_exp = be[EW-1:0];
    io.in_b_man = bm[MW-1:0];
    io.in_tag   = t;
  endtask

  task automatic dir(input string nm, input bit sub,
      input bit as, input int ae, input longint am,
      input bit bs, input int be, input longint bm,
      input bit es, input int ee, input longint em, input bit eo);
    int acc;
    bit got;
    logic [TW-1:0] t;
    got = 0;
    t = tg;
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    drive(sub, as, ae, am, bs, be, bm, t);
    @(negedge clk);
    acc = cyc + 1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    tg = tg + 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (io.out_valid) got = 1;
    end
    chk({nm, "_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({nm, "_lat"}, 64'(cyc - acc), 64'd4);
      chk(nm, pk(io.out_sgn, io.out_exp, io.out_man,
                 io.out_tag, io.out_ovf),
              pk(es, ee[EW-1:0], em[MW-1:0], t, eo));
    end
  endtask

  bit     s_sub[8] = '{0, 1, 0, 1, 0, 0, 1, 1};
  bit     s_as [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int     s_ae [8] = '{5, 10, 40, 5, 63, 7, 9, 1};
  longint s_am [8] = '{'h200000, 'h300000, 0, 'h040000,
                       'h200000, 0, 'h123456, 'h300000};
  bit     s_bs [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
  int     s_be [8] = '{5, 10, 3, 4, 63, 3, 2, 1};
  longint s_bm [8] = '{'h200000, 'h200000, 'h300000, 'h200000,
                       'h200000, 0, 0, 'h2C0000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, tries;
    bit got;
    io.in_valid = 0; io.in_sub = 0;
    io.in_a_sgn = 0; io.in_b_sgn = 0;
    io.in_a_exp = '0; io.in_b_exp = '0;
    io.in_a_man = '0; io.in_b_man = '0;
    io.in_tag = '0; io.out_ready = 0; io.clr_sticky = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);
    chk("rst_sticky", 64'(io.ovf_sticky), 64'd0);
    chk("rst_outs", pk(io.out_sgn, io.out_exp, io.out_man,
                       io.out_tag, io.out_ovf), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    dir("carry", 0, 0, 5, 'h200000, 0, 5, 'h200000,
        0, 6, 'h200000, 0);
    dir("cancel", 1, 0, 10, 'h300000, 0, 10, 'h200000,
        0, 9, 'h200000, 0);
    dir("self_sub", 1, 0, 10, 'h300000, 0, 10, 'h300000,
        0, 0, 0, 0);
    dir("zero_byp", 0, 0, 40, 0, 1, 3, 'h300000,
        1, 3, 'h300000, 0);
    dir("swap_neg", 1, 0, 5, 'h040000, 0, 4, 'h200000,
        1, 3, 'h300000, 0);
    dir("eq_exp_neg", 0, 0, 4, 'h200000, 1, 4, 'h300000,
        1, 3, 'h200000, 0);
    dir("far_align", 0, 0, 40, 'h200000, 0, 3, 'h3FFFFF,
        0, 40, 'h200000, 0);
    dir("d_mw_m1", 0, 0, 30, 'h200000, 0, 9, 'h200000,
        0, 30, 'h200001, 0);
    dir("both_zero", 0, 1, 7, 0, 0, 3, 0,
        0, 0, 0, 0);
    dir("exp_floor", 1, 0, 1, 'h300000, 0, 1, 'h2C0000,
        0, 0, 'h080000, 0);
    chk("sticky_idle", 64'(io.ovf_sticky), 64'd0);
    dir("overflow", 0, 0, 63, 'h200000, 0, 63, 'h200000,
        0, 63, 'h3FFFFF, 1);
    @(negedge clk);
    chk("sticky_set", 64'(io.ovf_sticky), 64'd1);

    @(posedge clk); #1 io.clr_sticky = 1'b1;
    @(posedge clk); #1 io.clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_clr", 64'(io.ovf_sticky), 64'd0);

    @(posedge clk); #1 io.clr_sticky = 1'b1;
    dir("ovf_again", 0, 1, 63, 'h300000, 1, 63, 'h300000,
        1, 63, 'h3FFFFF, 1);
    @(negedge clk);
    chk("sticky_set_wins", 64'(io.ovf_sticky), 64'd1);
    @(negedge clk);
    chk("sticky_clr2", 64'(io.ovf_sticky), 64'd0);
    @(posedge clk); #1 io.clr_sticky = 1'b0;

    n0 = nout;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          drive(s_sub[k], s_as[k], s_ae[k], s_am[k],
                s_bs[k], s_be[k], s_bm[k], TW'(8 + k));
          tries = 0;
          do begin
            @(negedge clk);
            tries++;
          end while (!io.in_ready && tries < 100);
        end
        @(posedge clk); #1 io.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 120; c++) begin
          @(posedge clk); #1;
          io.out_ready = 1'($urandom_range(0, 1));
        end
        io.out_ready = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    chk("stream_count", 64'(nout - n0), 64'd8);
    chk("stream_drained", 64'(sbq.size()), 64'd0);

    @(posedge clk); #1;
    io.out_ready = 1'b0;
    drive(0, 0, 63, 'h200000, 0, 63, 'h200000, 4'h3);
    @(posedge clk); #1;
    drive(0, 0, 5, 'h200000, 0, 5, 'h200000, 4'h4);
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (io.out_valid) got = 1;
    end
    chk("stall_seen", 64'(got), 64'd1);
    repeat (2) @(negedge clk);
    chk("stall_in_ready", 64'(io.in_ready), 64'd0);
    @(posedge clk); #1 io.out_ready = 1'b1;
    @(posedge clk); #1 io.out_ready = 1'b0;
    io.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_sticky", 64'(io.ovf_sticky), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(io.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(io.in_ready), 64'd1);
    chk("midrst_sticky", 64'(io.ovf_sticky), 64'd0);
    chk("midrst_outs", pk(io.out_sgn, io.out_exp, io.out_man,
                          io.out_tag, io.out_ovf), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dir("post_rst", 1, 0, 10, 'h300000, 0, 10, 'h200000,
        0, 9, 'h200000, 0);
    repeat (6) @(negedge clk);
    chk("post_rst_drained", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
